// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: key wait, input load, NR rounds
// (last one without MixColumns), then a done/ack handshake.
module aes_round_ctrl #(
  parameter int NR = 14,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          mode_i,
  input  logic          key_ready_i,
  input  logic          ack_i,
  output logic          ready_o,
  output logic          busy_o,
  output logic          mode_o,
  output logic [RW-1:0] round_o,
  output logic          load_o,
  output logic          round_en_o,
  output logic          mix_bypass_o,
  output logic          done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYWAIT,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_e;

  localparam logic [RW-1:0] NR_C   = RW'(NR);
  localparam logic [RW-1:0] LAST_C = RW'(NR - 1);
  localparam logic [RW-1:0] ONE_C  = RW'(1);

  state_e        state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d  = mode_i;
          state_d = key_ready_i ? S_INIT : S_KEYWAIT;
        end
      end
      S_KEYWAIT: begin
        if (key_ready_i) state_d = S_INIT;
      end
      S_INIT: begin
        cnt_d   = ONE_C;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        cnt_d = cnt_q + ONE_C;
        if (cnt_q == LAST_C) state_d = S_FINAL;
      end
      S_FINAL: begin
        cnt_d   = '0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Every output is a pure decode of state/cnt/mode registers.
  assign ready_o      = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign mode_o       = mode_q;
  assign load_o       = (state_q == S_INIT);
  assign round_en_o   = (state_q == S_ROUND) || (state_q == S_FINAL);
  assign mix_bypass_o = (state_q == S_FINAL);
  assign done_o       = (state_q == S_DONE);

  always_comb begin
    round_o = '0;
    unique case (state_q)
      S_INIT:  round_o = mode_q ? NR_C : '0;
      S_ROUND: round_o = mode_q ? (NR_C - cnt_q) : cnt_q;
      S_FINAL: round_o = mode_q ? '0 : NR_C;
      default: round_o = '0;
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: NR=14 and NR=10 instances on shared inputs,
// a position-based reference model, vector tables and corner sequences.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst, start, mode, key, ack;

  logic       rdy14, bsy14, mo14, ld14, en14, byp14, dn14;
  logic [3:0] rnd14;
  logic       rdy10, bsy10, mo10, ld10, en10, byp10, dn10;
  logic [3:0] rnd10;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(14), .RW(4)) dut14 (
    .clk(clk), .rst(rst), .start_i(start), .mode_i(mode),
    .key_ready_i(key), .ack_i(ack),
    .ready_o(rdy14), .busy_o(bsy14), .mode_o(mo14), .round_o(rnd14),
    .load_o(ld14), .round_en_o(en14), .mix_bypass_o(byp14),
    .done_o(dn14)
  );

  aes_round_ctrl #(.NR(10), .RW(4)) dut10 (
    .clk(clk), .rst(rst), .start_i(start), .mode_i(mode),
    .key_ready_i(key), .ack_i(ack),
    .ready_o(rdy10), .busy_o(bsy10), .mode_o(mo10), .round_o(rnd10),
    .load_o(ld10), .round_en_o(en10), .mix_bypass_o(byp10),
    .done_o(dn10)
  );

  wire [10:0] out14 = {rdy14, bsy14, mo14, ld14, en14, byp14, dn14, rnd14};
  wire [10:0] out10 = {rdy10, bsy10, mo10, ld10, en10, byp10, dn10, rnd10};
  localparam logic [10:0] RST_VAL = 11'b100_0000_0000;

  int n_chk = 0;
  int n_pass = 0;

  // Model position: -2 idle, -1 key wait, 0 load, 1..nr rounds, nr+1 done.
  int p14 = -2;
  int p10 = -2;
  bit m14 = 1'b0;
  bit m10 = 1'b0;

  typedef struct {
    logic       st, md, kr, ak;
    logic [3:0] rnd;
    logic       ld, en, byp, dn, rdy;
  } vec_t;

  vec_t vt[34];

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
  endtask

  function automatic logic [10:0] exp_out(int pos, bit m, int nr);
    logic rdy, ld, en, byp, dn;
    int r;
    rdy = (pos == -2);
    ld  = (pos == 0);
    en  = (pos >= 1) && (pos <= nr);
    byp = (pos == nr);
    dn  = (pos == nr + 1);
    r   = (pos >= 0 && pos <= nr) ? (m ? nr - pos : pos) : 0;
    return {rdy, !rdy, m, ld, en, byp, dn, 4'(r)};
  endfunction

  task automatic step(inout int pos, inout bit m, input int nr);
    if (pos == -2) begin
      if (start) begin
        m   = mode;
        pos = key ? 0 : -1;
      end
    end else if (pos == -1) begin
      if (key) pos = 0;
    end else if (pos <= nr) begin
      pos++;
    end else if (ack) begin
      pos = -2;
    end
  endtask

  task automatic model_reset();
    p14 = -2; p10 = -2; m14 = 1'b0; m10 = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      step(p14, m14, 14);
      step(p10, m10, 10);
    end
    #1;
    chk("model14", 32'(out14), 32'(exp_out(p14, m14, 14)));
    chk("model10", 32'(out10), 32'(exp_out(p10, m10, 10)));
    chk("excl14", 32'(($countones({ld14, en14, dn14}) <= 1) &&
                      (!byp14 || en14)), 32'd1);
    chk("excl10", 32'(($countones({ld10, en10, dn10}) <= 1) &&
                      (!byp10 || en10)), 32'd1);
  endtask

  task automatic flush();
    start = 1'b0; ack = 1'b1; key = 1'b1;
    repeat (2) tick();
    ack = 1'b0;
  endtask

  initial begin
    int n;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 17; i++) begin
        vec_t v;
        v = '{default: '0};
        v.st = (i == 0);
        v.md = 1'(m);
        v.kr = 1'b1;
        v.ak = (i == 16);
        if (i == 0) begin
          v.ld = 1'b1; v.rnd = m ? 4'd14 : 4'd0;
        end else if (i <= 13) begin
          v.en = 1'b1; v.rnd = m ? 4'(14 - i) : 4'(i);
        end else if (i == 14) begin
          v.en = 1'b1; v.byp = 1'b1; v.rnd = m ? 4'd0 : 4'd14;
        end else if (i == 15) begin
          v.dn = 1'b1;
        end else begin
          v.rdy = 1'b1;
        end
        vt[m*17 + i] = v;
      end
    end

    rst = 1'b1; start = 1'b0; mode = 1'b0; key = 1'b0; ack = 1'b0;
    #2;
    chk("rst_val14", 32'(out14), 32'(RST_VAL));
    chk("rst_val10", 32'(out10), 32'(RST_VAL));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Encrypt then decrypt, ack on the first done cycle.
    for (int k = 0; k < 34; k++) begin
      start = vt[k].st; mode = vt[k].md; key = vt[k].kr; ack = vt[k].ak;
      tick();
      chk($sformatf("vec%0d", k),
          32'({rdy14, mo14, ld14, en14, byp14, dn14, rnd14}),
          32'({vt[k].rdy, vt[k].md, vt[k].ld, vt[k].en, vt[k].byp,
               vt[k].dn, vt[k].rnd}));
      if (k == 10)
        chk("nr10_final", 32'({en10, byp10, rnd10}), 32'({2'b11, 4'd10}));
      if (k == 11)
        chk("nr10_done", 32'({dn10, en10}), 32'b10);
    end
    start = 1'b0;
    flush();

    // Key wait for 5 cycles after accept.
    start = 1'b1; mode = 1'b0; key = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("keywait", 32'({bsy14, rdy14, ld14, en14, dn14}), 32'b10000);
      if (i < 4) tick();
    end
    key = 1'b1;
    tick();
    chk("kw_load", 32'({ld14, rnd14}), 32'({1'b1, 4'd0}));
    n = 1;
    while (!dn14 && n < 40) begin
      tick();
      n++;
    end
    chk("kw_done_lat", 32'(n), 32'd16);
    flush();

    // Backpressure with spurious starts.
    start = 1'b1; mode = 1'b1; key = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    chk("bp_done", 32'(dn14), 32'd1);
    for (int i = 0; i < 10; i++) begin
      start = 1'(i % 2); ack = 1'b0;
      tick();
      chk("bp_hold", 32'({dn14, rdy14, mo14}), 32'b101);
    end
    start = 1'b0; ack = 1'b1;
    tick();
    chk("bp_release", 32'({dn14, rdy14}), 32'b01);
    ack = 1'b0;
    flush();

    // Reset mid-block at round 7, then a clean restart.
    start = 1'b1; mode = 1'b0; key = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (rnd14 != 4'd7 && n < 20) begin
      tick();
      n++;
    end
    chk("mid_round7", 32'({en14, rnd14}), 32'({1'b1, 4'd7}));
    #2 rst = 1'b1;
    #1;
    chk("async_rst14", 32'(out14), 32'(RST_VAL));
    chk("async_rst10", 32'(out10), 32'(RST_VAL));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1; mode = 1'b0; key = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!dn14 && n < 40) begin
      tick();
      n++;
    end
    chk("rst_restart_lat", 32'(n), 32'd16);
    flush();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(3) == 0);
      mode  = 1'($urandom);
      key   = ($urandom_range(2) != 0);
      ack   = ($urandom_range(2) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
